// File: rtl/bomb_controller.sv
// Single-bomb lifecycle: place, fuse, probe the wall map to size four explosion
// arms, hold the explosion, clear. Also drives the bomb/explosion pixel layers.
module bomb_controller #(
  parameter int          FUSE_CYCLES    = 200_000_000,
  parameter int          EXPLODE_CYCLES = 50_000_000,
  parameter int          RANGE          = 2,
  parameter int          H_OFF          = 144,
  parameter int          V_OFF          = 35,
  parameter logic [11:0] BOMB_RGB       = 12'h222,
  parameter logic [11:0] EXPL_RGB       = 12'hF80
) (
  input  logic        sys_clk,
  input  logic        Reset,
  input  logic        place_btn,
  input  logic [9:0]  b_x,
  input  logic [9:0]  b_y,
  input  logic [9:0]  v_x,
  input  logic [9:0]  v_y,
  output logic        probe_valid,
  output logic [4:0]  probe_tx,
  output logic [3:0]  probe_ty,
  input  logic        probe_hard,
  input  logic        probe_soft,
  output logic        destroy_valid,
  output logic [4:0]  destroy_tx,
  output logic [3:0]  destroy_ty,
  output logic        bomb_active,
  output logic [4:0]  bomb_tx,
  output logic [3:0]  bomb_ty,
  output logic        player_hit,
  output logic        bomb_rgb_en,
  output logic [11:0] bomb_rgb,
  output logic        explosion_rgb_en,
  output logic [11:0] explosion_rgb
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_PROBE_REQ, S_PROBE_WAIT, S_EXPLODE
  } state_t;

  typedef enum logic [1:0] {D_R, D_L, D_D, D_U} dir_t;

  localparam logic [6:0]  GRID_W    = 7'd20;
  localparam logic [6:0]  GRID_H    = 7'd15;
  localparam logic [2:0]  RANGE_3   = 3'(RANGE);
  localparam logic [31:0] FUSE_LOAD = 32'(FUSE_CYCLES - 1);
  localparam logic [31:0] EXPL_LOAD = 32'(EXPLODE_CYCLES - 1);

  state_t           state, state_n;
  dir_t             dir, dir_n;
  logic [2:0]       step, step_n;
  logic [3:0][2:0]  arm, arm_n;
  logic [31:0]      cnt, cnt_n;
  logic [4:0]       bomb_tx_n;
  logic [3:0]       bomb_ty_n;
  logic             btn_prev;
  logic             place_edge;
  logic             close_arm;

  logic [6:0]       tgt_x, tgt_y;
  logic             tgt_in;

  logic             pix_vis;
  logic [4:0]       pix_tx, ply_tx;
  logic [3:0]       pix_ty, ply_ty;

  // True when tile (tx,ty) lies on the cross centred at (cx,cy) with the given arms.
  function automatic logic in_live(input logic [4:0] tx, input logic [3:0] ty,
                                   input logic [4:0] cx, input logic [3:0] cy,
                                   input logic [3:0][2:0] a);
    logic [4:0] dx_r, dx_l;
    logic [3:0] dy_d, dy_u;
    dx_r = tx - cx;
    dx_l = cx - tx;
    dy_d = ty - cy;
    dy_u = cy - ty;
    in_live = ((ty == cy) && (tx >= cx) && (dx_r <= {2'b00, a[D_R]})) ||
              ((ty == cy) && (cx >= tx) && (dx_l <= {2'b00, a[D_L]})) ||
              ((tx == cx) && (ty >= cy) && (dy_d <= {1'b0, a[D_D]}))  ||
              ((tx == cx) && (cy >= ty) && (dy_u <= {1'b0, a[D_U]}));
  endfunction

  assign place_edge = place_btn & ~btn_prev;

  assign pix_vis = (v_x >= 10'(H_OFF)) && (v_y >= 10'(V_OFF));
  assign pix_tx  = 5'((v_x - 10'(H_OFF)) >> 5);
  assign pix_ty  = 4'((v_y - 10'(V_OFF)) >> 5);
  assign ply_tx  = 5'(({1'b0, b_x} + 11'd16 - 11'(H_OFF)) >> 5);
  assign ply_ty  = 4'(({1'b0, b_y} + 11'd16 - 11'(V_OFF)) >> 5);

  // Negative targets wrap far above the grid bounds, so one unsigned compare covers both edges.
  always_comb begin
    tgt_x = {2'b00, bomb_tx};
    tgt_y = {3'b000, bomb_ty};
    case (dir)
      D_R: tgt_x = {2'b00, bomb_tx} + {4'b0000, step};
      D_L: tgt_x = {2'b00, bomb_tx} - {4'b0000, step};
      D_D: tgt_y = {3'b000, bomb_ty} + {4'b0000, step};
      D_U: tgt_y = {3'b000, bomb_ty} - {4'b0000, step};
      default: ;
    endcase
    tgt_in = (tgt_x < GRID_W) && (tgt_y < GRID_H);
  end

  // Probe handshake: probe_valid is a one-cycle strobe in PROBE_REQ; the map answers
  // on probe_hard/probe_soft during the following cycle, which is always PROBE_WAIT.
  assign probe_valid   = (state == S_PROBE_REQ) && tgt_in;
  assign probe_tx      = probe_valid ? tgt_x[4:0] : 5'd0;
  assign probe_ty      = probe_valid ? tgt_y[3:0] : 4'd0;
  assign destroy_valid = (state == S_PROBE_WAIT) && !probe_hard && probe_soft;
  assign destroy_tx    = destroy_valid ? tgt_x[4:0] : 5'd0;
  assign destroy_ty    = destroy_valid ? tgt_y[3:0] : 4'd0;

  assign bomb_active   = (state != S_IDLE);
  assign bomb_rgb      = BOMB_RGB;
  assign explosion_rgb = EXPL_RGB;

  always_comb begin
    state_n   = state;
    dir_n     = dir;
    step_n    = step;
    arm_n     = arm;
    cnt_n     = cnt;
    bomb_tx_n = bomb_tx;
    bomb_ty_n = bomb_ty;
    close_arm = 1'b0;
    case (state)
      S_IDLE: begin
        if (place_edge) begin
          bomb_tx_n = ply_tx;
          bomb_ty_n = ply_ty;
          cnt_n     = FUSE_LOAD;
          state_n   = S_ARMED;
        end
      end
      S_ARMED: begin
        if (cnt == 32'd0) begin
          state_n = S_PROBE_REQ;
          dir_n   = D_R;
          step_n  = 3'd1;
          arm_n   = '0;
        end else begin
          cnt_n = cnt - 32'd1;
        end
      end
      S_PROBE_REQ: begin
        if (tgt_in) state_n = S_PROBE_WAIT;
        else        close_arm = 1'b1;
      end
      S_PROBE_WAIT: begin
        if (probe_hard) begin
          arm_n[dir] = step - 3'd1;
          close_arm  = 1'b1;
        end else if (probe_soft) begin
          arm_n[dir] = step;
          close_arm  = 1'b1;
        end else begin
          arm_n[dir] = step;
          if (step == RANGE_3) begin
            close_arm = 1'b1;
          end else begin
            step_n  = step + 3'd1;
            state_n = S_PROBE_REQ;
          end
        end
      end
      S_EXPLODE: begin
        if (cnt == 32'd0) state_n = S_IDLE;
        else              cnt_n   = cnt - 32'd1;
      end
      default: state_n = S_IDLE;
    endcase
    if (close_arm) begin
      step_n = 3'd1;
      if (dir == D_U) begin
        cnt_n   = EXPL_LOAD;
        state_n = S_EXPLODE;
      end else begin
        dir_n   = dir_t'(dir + 2'd1);
        state_n = S_PROBE_REQ;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge Reset) begin
    if (Reset) begin
      state    <= S_IDLE;
      dir      <= D_R;
      step     <= 3'd0;
      arm      <= '0;
      cnt      <= 32'd0;
      bomb_tx  <= 5'd0;
      bomb_ty  <= 4'd0;
      btn_prev <= 1'b0;
    end else begin
      state    <= state_n;
      dir      <= dir_n;
      step     <= step_n;
      arm      <= arm_n;
      cnt      <= cnt_n;
      bomb_tx  <= bomb_tx_n;
      bomb_ty  <= bomb_ty_n;
      btn_prev <= place_btn;
    end
  end

  always_ff @(posedge sys_clk or posedge Reset) begin
    if (Reset) begin
      bomb_rgb_en      <= 1'b0;
      explosion_rgb_en <= 1'b0;
      player_hit       <= 1'b0;
    end else begin
      bomb_rgb_en      <= (state == S_ARMED || state == S_PROBE_REQ || state == S_PROBE_WAIT) &&
                          pix_vis && (pix_tx == bomb_tx) && (pix_ty == bomb_ty);
      explosion_rgb_en <= (state == S_EXPLODE) && pix_vis &&
                          in_live(pix_tx, pix_ty, bomb_tx, bomb_ty, arm);
      player_hit       <= (state == S_EXPLODE) &&
                          in_live(ply_tx, ply_ty, bomb_tx, bomb_ty, arm);
    end
  end

endmodule
